// File: rtl/tc_ram_lat_pkg.sv
// Shared types and constants for the TC latency-RAM master.
package tc_ram_lat_pkg;

  // Master FSM states; the encoding is visible on the dbg_state output.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Encoding of req_write.
  localparam logic OP_LOAD = 1'b0;
  localparam logic OP_SAVE = 1'b1;

  // 8-bit increment that sticks at 255.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/tc_ram_lat_timer.sv
// Wait-cycle counter for the latency-RAM master. It is cleared when a request
// is accepted, counts while enabled, and raises expire combinationally once
// TIMEOUT-1 cycles have been counted. With TIMEOUT=0 expire never fires.
module tc_ram_lat_timer #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  if (TIMEOUT == 0) begin : g_no_timeout
    assign o_expire = 1'b0;
  end else begin : g_timeout
    localparam int CW = (TIMEOUT == 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] r_cnt;

    assign o_expire = (r_cnt == LAST);

    // Count wait cycles; hold at LAST rather than wrapping.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_cnt <= '0;
      end else if (i_clear) begin
        r_cnt <= '0;
      end else if (i_enable && !o_expire) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/tc_ram_lat_master.sv
// Initiator for the TC latency-RAM protocol. Accepts one load/save request at
// a time, holds the RAM strobe/address/data until ram_ready (or a timeout),
// then presents a single response until the consumer takes it.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both 1. The request side is sampled only in IDLE (req_ready=1 there);
// the response side holds resp_valid/resp_rdata/resp_err stable until the
// edge where resp_ready=1 is seen, and resp_valid never drops without it
// (except on reset).
module tc_ram_lat_master
  import tc_ram_lat_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  // core-side request
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  // core-side response
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  // latency RAM side
  output logic              ram_load,
  output logic              ram_save,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_in0,
  input  logic              ram_ready,
  input  logic [DATA_W-1:0] ram_out0,
  // status / debug
  output logic [7:0]        err_count,
  output logic [1:0]        dbg_state
);

  state_t            r_state;
  logic              r_load;
  logic              r_save;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_resp_valid;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;
  logic [7:0]        r_err_cnt;

  logic              w_accept;
  logic              w_in_wait;
  logic              w_expire;

  assign w_accept  = (r_state == ST_IDLE) && req_valid;
  assign w_in_wait = (r_state == ST_WAIT);

  tc_ram_lat_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_accept),
    .i_enable (w_in_wait),
    .o_expire (w_expire)
  );

  // req_ready is gated by rst so nothing looks acceptable during reset.
  assign req_ready   = (r_state == ST_IDLE) && !rst;
  assign resp_valid  = r_resp_valid;
  assign resp_rdata  = r_rdata;
  assign resp_err    = r_err;
  assign ram_load    = r_load;
  assign ram_save    = r_save;
  assign ram_address = r_addr;
  assign ram_in0     = r_wdata;
  assign err_count   = r_err_cnt;
  assign dbg_state   = r_state;

  // Main FSM: issue strobes, wait for ram_ready or timeout, hold the response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_load       <= 1'b0;
      r_save       <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_resp_valid <= 1'b0;
      r_rdata      <= '0;
      r_err        <= 1'b0;
      r_err_cnt    <= 8'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_save  <= (req_write == OP_SAVE);
            r_load  <= (req_write == OP_LOAD);
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // ram_ready is checked first so it wins over a same-edge timeout.
          if (ram_ready) begin
            r_rdata      <= r_load ? ram_out0 : '0;
            r_err        <= 1'b0;
            r_load       <= 1'b0;
            r_save       <= 1'b0;
            r_resp_valid <= 1'b1;
            r_state      <= ST_RESP;
          end else if (w_expire) begin
            r_rdata      <= '0;
            r_err        <= 1'b1;
            r_load       <= 1'b0;
            r_save       <= 1'b0;
            r_resp_valid <= 1'b1;
            r_err_cnt    <= sat_inc8(r_err_cnt);
            r_state      <= ST_RESP;
          end
        end
        ST_RESP: begin
          // ram_ready is ignored here; only the consumer moves us on.
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_state      <= ST_IDLE;
          end
        end
        default: begin
          r_load       <= 1'b0;
          r_save       <= 1'b0;
          r_resp_valid <= 1'b0;
          r_state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/tc_ram_lat_master.md
Name: tc_ram_lat_master

Overview:
Initiator for the latency-RAM protocol (load/save/address/in0 in; ready/out0 back). It accepts single read/write requests from a core-side valid/ready port, drives and holds the RAM strobes until the RAM's ready, then returns a one-entry response with read data or a timeout error. It sits between a CPU/load-store unit and any TC latency RAM instance.

Parameters:
ADDR_W, 16, address width
DATA_W, 16, data width
TIMEOUT, 64, max cycles waiting for ram_ready before abort; 0 disables the timeout

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
req_valid  in  1  request present
req_ready  out  1  master can accept a request
req_write  in  1  1=save, 0=load
req_addr  in  ADDR_W  request address
req_wdata  in  DATA_W  write data
resp_valid  out  1  response present
resp_ready  in  1  consumer takes response
resp_rdata  out  DATA_W  read data; 0 for writes and errors
resp_err  out  1  timeout abort
ram_load  out  1  RAM load strobe
ram_save  out  1  RAM save strobe
ram_address  out  ADDR_W  RAM address
ram_in0  out  DATA_W  RAM write data
ram_ready  in  1  RAM operation complete
ram_out0  in  DATA_W  RAM read data, valid while ram_ready=1
err_count  out  8  saturating timeout count

Behaviour:
- States: IDLE, WAIT, RESP. Reset: state IDLE, all outputs 0, counters 0; req_ready=0 while rst=1.
- IDLE: req_ready=1. On an edge with req_valid=1: latch write/addr/wdata into ram_address/ram_in0; ram_save=req_write, ram_load=!req_write, both registered (high from that edge); go WAIT; clear wait counter.
- WAIT: req_ready=0; strobes, ram_address, and ram_in0 held stable. Each edge: if ram_ready=1, capture resp_rdata=ram_out0 (load) or 0 (save), resp_err=0, drop strobes, resp_valid=1, go RESP. Else if TIMEOUT!=0 and the counter equals TIMEOUT-1: drop strobes, resp_err=1, resp_rdata=0, resp_valid=1, err_count+=1 (saturate at 255), go RESP. Else increment the counter.
- ram_ready wins over timeout when both apply at the same edge.
- Minimum latency: request accepted at edge N, ram_ready sampled at edge N+1, resp_valid high from edge N+1.
- RESP: resp_valid, rdata, and err held until an edge with resp_ready=1; then resp_valid=0, go IDLE. Strobes are guaranteed low for at least one cycle between operations.
- ram_ready outside WAIT is ignored.
- Exactly one of ram_load/ram_save is high, and only in WAIT.
- Counter width: clog2(TIMEOUT+1), minimum 1; no wrap.
- Reset mid-operation: strobes and resp_valid drop asynchronously; the in-flight transaction is discarded; err_count clears.

Decomposition:
- Package tc_ram_lat_pkg: state enum (IDLE/WAIT/RESP), op constants OP_LOAD=0 and OP_SAVE=1.
- One sub-module, tc_ram_lat_timer: clear/enable/expire counter parameterised by TIMEOUT, with expire tied 0 when TIMEOUT=0.
- Test RAM model for the bench: fixed configurable latency of 3 cycles.

Test Plan:
- Write 0x0001 to addr 0x0000, then read addr 0x0000 -> ram_save high until ready; resp_err=0, resp_rdata=0; the read returns resp_rdata=0x0001.
- Write 0x0002 to addr 0x0001, then read addr 0x0000 -> returns 0x0001; read addr 0x0001 returns 0x0002; ram_address/ram_in0 stable throughout WAIT.
- Back-to-back requests with req_valid held, RAM latency 3 -> each resp_valid 3 cycles after acceptance; strobes low ≥1 cycle between ops; req_ready=0 outside IDLE.
- Hold resp_ready=0 for 5 cycles after a read of 0x0001 -> resp_valid and resp_rdata=0x0001 held; no new request accepted; ram_ready pulses in RESP ignored.
- TIMEOUT=8, ram_ready tied 0, read addr 0x0005 -> strobe high exactly 8 cycles; resp_err=1, resp_rdata=0, err_count=1; after 256 timeouts err_count stays 255.
- Assert rst 2 cycles into WAIT -> ram_load and resp_valid drop immediately without a clock; after release req_ready=1 and no stale response appears.
